imem_uart_loader: RTL and testbench

Boot-time instruction loader between a host UART line and the instruction memory's write port. It receives a length-prefixed, checksummed byte stream and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory addresses starting at 0. The processor core is held in reset until a load completes cleanly.

---
 rtl/imem_uart_loader.sv | 245 ++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: boot-time loader that receives a length-prefixed,
// XOR-checksummed byte stream over an 8N1 UART line. It packs the bytes
// into little-endian 32-bit words and writes them to instruction memory
// from address 0 upward. The core is held in reset until a load finishes
// with a matching checksum.
//
// state  | meaning
// IDLE   | waiting for start after reset, nothing loaded yet
// LEN    | waiting for the word-count byte N
// DATA   | collecting 4*N data bytes, writing one word per 4 bytes
// CSUM   | waiting for the checksum byte
// DONE   | image loaded and verified, core released
// ERR    | load aborted (bad length, framing error or bad checksum)
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_WORDS  = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    output logic              cpu_reset,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    logic rx_meta, rx_s, rx_prev;

    rx_state_t   rx_state, rx_state_nx;
    logic [15:0] rx_cnt, rx_cnt_nx;
    logic [2:0]  rx_bit, rx_bit_nx;
    logic [7:0]  rx_shift, rx_shift_nx;
    logic        byte_valid, byte_valid_nx;
    logic        frame_err, frame_err_nx;

    state_t            state, state_nx;
    logic [7:0]        n_words, n_words_nx;
    logic [1:0]        idx, idx_nx;
    logic [23:0]       word_buf, word_buf_nx;
    logic [7:0]        csum, csum_nx;
    logic [ADDR_W:0]   word_count_nx;
    logic              imem_we_nx;
    logic [ADDR_W-1:0] imem_addr_nx;
    logic [31:0]       imem_wdata_nx;
    logic              arm;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // UART receiver registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nx;
            rx_cnt     <= rx_cnt_nx;
            rx_bit     <= rx_bit_nx;
            rx_shift   <= rx_shift_nx;
            byte_valid <= byte_valid_nx;
            frame_err  <= frame_err_nx;
        end
    end

    // UART receiver next state: down-counter times each bit from the start edge.
    always_comb begin
        rx_state_nx   = rx_state;
        rx_cnt_nx     = rx_cnt;
        rx_bit_nx     = rx_bit;
        rx_shift_nx   = rx_shift;
        byte_valid_nx = 1'b0;
        frame_err_nx  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_nx = RX_START;
                    rx_cnt_nx   = HALF_LAST;
                end
            end
            RX_START: begin
                if (rx_cnt == 16'd0) begin
                    if (!rx_s) begin
                        rx_state_nx = RX_DATA;
                        rx_cnt_nx   = BIT_LAST;
                        rx_bit_nx   = 3'd0;
                    end else begin
                        rx_state_nx = RX_IDLE;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_shift_nx = {rx_s, rx_shift[7:1]};
                    rx_cnt_nx   = BIT_LAST;
                    if (rx_bit == 3'd7) begin
                        rx_state_nx = RX_STOP;
                    end else begin
                        rx_bit_nx = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_s) begin
                        byte_valid_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                    rx_state_nx = RX_IDLE;
                end else begin
                    rx_cnt_nx = rx_cnt - 16'd1;
                end
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // Load FSM and write-port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            n_words    <= '0;
            idx        <= '0;
            word_buf   <= '0;
            csum       <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state      <= state_nx;
            n_words    <= n_words_nx;
            idx        <= idx_nx;
            word_buf   <= word_buf_nx;
            csum       <= csum_nx;
            word_count <= word_count_nx;
            imem_we    <= imem_we_nx;
            imem_addr  <= imem_addr_nx;
            imem_wdata <= imem_wdata_nx;
        end
    end

    // Load FSM next state: byte 3 of each word bypasses the buffer straight into the write.
    always_comb begin
        state_nx      = state;
        n_words_nx    = n_words;
        idx_nx        = idx;
        word_buf_nx   = word_buf;
        csum_nx       = csum;
        word_count_nx = word_count;
        imem_we_nx    = 1'b0;
        imem_addr_nx  = imem_addr;
        imem_wdata_nx = imem_wdata;
        arm           = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                arm = start;
            end
            S_LEN: begin
                if (frame_err) begin
                    state_nx = S_ERR;
                end else if (byte_valid) begin
                    if (rx_shift == 8'd0 || int'(rx_shift) > DEPTH_WORDS) begin
                        state_nx = S_ERR;
                    end else begin
                        n_words_nx = rx_shift;
                        state_nx   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (frame_err) begin
                    state_nx = S_ERR;
                end else if (byte_valid) begin
                    csum_nx = csum ^ rx_shift;
                    case (idx)
                        2'd0: word_buf_nx[7:0]   = rx_shift;
                        2'd1: word_buf_nx[15:8]  = rx_shift;
                        2'd2: word_buf_nx[23:16] = rx_shift;
                        default: begin
                            imem_we_nx    = 1'b1;
                            imem_addr_nx  = word_count[ADDR_W-1:0];
                            imem_wdata_nx = {rx_shift, word_buf};
                            word_count_nx = word_count + 1'b1;
                            if (int'(word_count) + 1 == int'(n_words)) begin
                                state_nx = S_CSUM;
                            end
                        end
                    endcase
                    idx_nx = idx + 2'd1;
                end
            end
            S_CSUM: begin
                if (frame_err) begin
                    state_nx = S_ERR;
                end else if (byte_valid) begin
                    state_nx = (rx_shift == csum) ? S_DONE : S_ERR;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (arm) begin
            state_nx      = S_LEN;
            word_count_nx = '0;
            idx_nx        = 2'd0;
            csum_nx       = 8'd0;
        end
    end

    assign busy      = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign cpu_reset = (state != S_DONE);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives UART byte streams and compares the
// memory writes and load outcome against a word-level model of the loader.
module tb_imem_uart_loader;

    localparam int CPB   = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          start;
    logic          cpu_reset;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int checks = 0;
    int passed = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [31:0]   wr_log[$];
    logic [AW-1:0] last_addr;
    logic [31:0]   last_wdata = '0;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .start(start),
        .cpu_reset(cpu_reset), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of the write port and status outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            last_wdata = '0;
            check("rst_cpu_reset", cpu_reset, 1);
            check("rst_imem_we", imem_we, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_imem_wdata", imem_wdata, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_word_count", word_count, 0);
        end else begin
            if (imem_we) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", imem_we, 0);
                end else begin
                    logic [AW-1:0] a;
                    logic [31:0]   d;
                    a = exp_addr_q.pop_front();
                    d = exp_data_q.pop_front();
                    check("imem_addr", imem_addr, a);
                    check("imem_wdata", imem_wdata, d);
                    check("word_count_at_write", word_count, {1'b0, a} + 1);
                    last_wdata = d;
                end
                wr_log.push_back(imem_wdata);
                last_addr = imem_addr;
            end else begin
                check("wdata_hold", imem_wdata, last_wdata);
            end
            check("cpu_reset_vs_done", cpu_reset, !done);
            check("done_err_exclusive", done & err, 0);
            check("busy_vs_status", busy & (done | err), 0);
        end
    end

    // Word-level model: pushes the writes a stream must cause and reports the
    // outcome (0 still loading, 1 done, 2 err), final word count and the index
    // of the byte that ends the load.
    task automatic model_load(input byte_q_t s, input int bad,
                              output int outcome, output int wc, output int term);
        int n;
        logic [7:0] x;
        outcome = 0;
        wc = 0;
        term = 1 << 30;
        x = 8'd0;
        if (s.size() == 0) return;
        n = int'(s[0]);
        if (bad == 0 || n == 0 || n > DEPTH) begin
            outcome = 2;
            term = 0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = 4 * w + k;
                if (i >= s.size()) return;
                if (i == bad) begin
                    outcome = 2;
                    term = i;
                    return;
                end
                x = x ^ s[i];
            end
            exp_addr_q.push_back(AW'(w));
            exp_data_q.push_back({s[4*w+4], s[4*w+3], s[4*w+2], s[4*w+1]});
            wc = w + 1;
        end
        if (4 * n + 1 >= s.size()) return;
        term = 4 * n + 1;
        outcome = (bad == term || s[term] != x) ? 2 : 1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic run_load(input byte_q_t s, input int bad, input bit rnd_start);
        int outcome, wc, term;
        wr_log.delete();
        model_load(s, bad, outcome, wc, term);
        pulse_start();
        @(negedge clk);
        check("armed_busy", busy, 1);
        check("armed_cpu_reset", cpu_reset, 1);
        check("armed_done", done, 0);
        check("armed_err", err, 0);
        check("armed_word_count", word_count, 0);
        for (int i = 0; i < s.size(); i++) begin
            if (rnd_start && i > 0 && i <= term && $urandom_range(0, 3) == 0) pulse_start();
            send_byte(s[i], (i == bad) ? 1'b0 : 1'b1);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (outcome != 0) begin
            check("end_done", done, outcome == 1);
            check("end_err", err, outcome == 2);
            check("end_busy", busy, 0);
            check("end_cpu_reset", cpu_reset, outcome != 1);
            check("end_word_count", word_count, wc);
        end
        check("writes_pending", exp_addr_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t s;
        int n, bad;
        logic [7:0] x;

        reset = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        reset = 1'b0;

        repeat (1000) begin
            @(negedge clk);
            check("idle_cpu_reset", cpu_reset, 1);
            check("idle_busy", busy, 0);
        end

        // Good two-word image; XOR of the data bytes is 0xF0.
        s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        run_load(s, -1, 1'b0);
        check("lit_writes", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("lit_word0", wr_log[0], 32'h00000013);
            check("lit_word1", wr_log[1], 32'h005000B3);
        end
        check("lit_done", done, 1);
        check("lit_cpu_reset", cpu_reset, 0);
        check("lit_word_count", word_count, 2);

        // Wrong checksums: both words still written, then err.
        s[9] = 8'hA1;
        run_load(s, -1, 1'b0);
        check("lit_bad_writes", wr_log.size(), 2);
        check("lit_bad_err", err, 1);
        check("lit_bad_done", done, 0);
        check("lit_bad_cpu_reset", cpu_reset, 1);
        s[9] = 8'hA0;
        run_load(s, -1, 1'b0);
        check("lit_a0_err", err, 1);

        // Illegal lengths.
        s = '{8'h00, 8'h11, 8'h22};
        run_load(s, -1, 1'b0);
        check("len0_err", err, 1);
        check("len0_writes", wr_log.size(), 0);
        s = '{8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(s, -1, 1'b0);
        check("len41_err", err, 1);
        check("len41_writes", wr_log.size(), 0);

        // Framing error on the 3rd data byte, then a clean reload.
        s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        run_load(s, 3, 1'b0);
        check("frame_err", err, 1);
        check("frame_writes", wr_log.size(), 0);
        run_load(s, -1, 1'b0);
        check("reload_done", done, 1);

        // Reset after 6 data bytes of an N=2 load.
        s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00};
        run_load(s, -1, 1'b0);
        check("partial_writes", wr_log.size(), 1);
        check("partial_busy", busy, 1);
        check("partial_word_count", word_count, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_word_count", word_count, 0);
        check("async_cpu_reset", cpu_reset, 1);
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (3) @(posedge clk);
        reset = 1'b0;
        s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        run_load(s, -1, 1'b0);
        check("after_reset_done", done, 1);

        // Randomized loads with illegal lengths, bad checksums, framing errors,
        // trailing bytes and start pulses while busy.
        for (int t = 0; t < 6; t++) begin
            s.delete();
            if ($urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 255);
            else n = $urandom_range(1, 8);
            s.push_back(8'(n));
            x = 8'd0;
            if (n >= 1 && n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    s.push_back(b);
                    x = x ^ b;
                end
                if ($urandom_range(0, 3) == 0) x = x ^ (8'd1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            repeat ($urandom_range(0, 2)) s.push_back(8'($urandom));
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s.size() - 1) : -1;
            run_load(s, bad, 1'b1);
        end

        // Full-depth image.
        s.delete();
        s.push_back(8'(DEPTH));
        x = 8'd0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            s.push_back(b);
            x = x ^ b;
        end
        s.push_back(x);
        run_load(s, -1, 1'b0);
        check("full_done", done, 1);
        check("full_word_count", word_count, 64);
        check("full_last_addr", last_addr, 63);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
